// File: rtl/cell_particle_streamer.sv
// cell_particle_streamer: reads a cell's particle count from a 2-cycle-latency
// position memory and streams every particle position out over valid/ready.
// Outstanding reads are credit-limited so the 4-entry output buffer never overflows.
module cell_particle_streamer #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  count_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rden,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_pid,
    output logic                  out_last
);

    typedef enum logic [2:0] {
        IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FINISH
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    state_t                  state;
    logic                    wait_cnt;
    logic [ADDR_WIDTH-1:0]   n_cnt;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    rd_part;     // current mem_rden is a particle read (not the count read)

    // Return-tracking pipeline aligned to the memory latency
    logic                    vld_p1, vld_p2;
    logic [ADDR_WIDTH-1:0]   pid_p1, pid_p2;
    logic                    last_p1, last_p2;

    // Output buffer
    logic [DATA_WIDTH-1:0]   fifo_data [4];
    logic [ADDR_WIDTH-1:0]   fifo_pid  [4];
    logic                    fifo_last [4];
    logic [1:0]              wr_ptr, rd_ptr;
    logic [2:0]              fifo_count;

    logic                    hs;
    logic [1:0]              inflight;
    logic [3:0]              credit_used;
    logic                    can_issue;
    logic [ADDR_WIDTH-1:0]   raw_cnt;

    function automatic logic [ADDR_WIDTH-1:0] clamp_count(input logic [ADDR_WIDTH-1:0] raw);
        return (raw > MAX_CNT) ? MAX_CNT : raw;
    endfunction

    function automatic logic count_over(input logic [ADDR_WIDTH-1:0] raw);
        return raw > MAX_CNT;
    endfunction

    assign raw_cnt   = mem_q[ADDR_WIDTH-1:0];
    assign out_valid = (fifo_count != 3'd0);
    assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_pid   = out_valid ? fifo_pid[rd_ptr]  : '0;
    assign out_last  = out_valid ? fifo_last[rd_ptr] : 1'b0;
    assign hs        = out_valid && out_ready;

    // Credits: buffered words, returns in the memory pipe, and the read on mem_rden now.
    // A handshake this cycle frees one slot, so a read may be issued in the same cycle.
    assign inflight    = 2'(vld_p1) + 2'(vld_p2);
    assign credit_used = 4'(fifo_count) + 4'(inflight) + 4'(rd_part);
    assign can_issue   = credit_used < (hs ? 4'd5 : 4'd4);

    // Sequencer: count read, particle read issue, drain and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            count_err <= 1'b0;
            mem_rden  <= 1'b0;
            mem_addr  <= '0;
            rd_part   <= 1'b0;
            wait_cnt  <= 1'b0;
            n_cnt     <= '0;
            next_addr <= '0;
        end else begin
            mem_rden <= 1'b0;
            rd_part  <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        count_err <= 1'b0;
                        mem_rden  <= 1'b1;
                        mem_addr  <= '0;
                        state     <= RD_CNT;
                    end
                end
                RD_CNT: begin
                    wait_cnt <= 1'b0;
                    state    <= WAIT_CNT;
                end
                WAIT_CNT: begin
                    if (!wait_cnt) begin
                        wait_cnt <= 1'b1;
                    end else if (raw_cnt == '0) begin
                        // Empty cell: DRAIN sees nothing outstanding and finishes at once
                        state <= DRAIN;
                    end else begin
                        // First read goes out with the count latch; the pipe is empty here
                        n_cnt     <= clamp_count(raw_cnt);
                        count_err <= count_over(raw_cnt);
                        mem_rden  <= 1'b1;
                        rd_part   <= 1'b1;
                        mem_addr  <= ADDR_WIDTH'(1);
                        next_addr <= ADDR_WIDTH'(2);
                        state     <= (clamp_count(raw_cnt) == ADDR_WIDTH'(1)) ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    if (can_issue) begin
                        mem_rden  <= 1'b1;
                        rd_part   <= 1'b1;
                        mem_addr  <= next_addr;
                        next_addr <= next_addr + ADDR_WIDTH'(1);
                        if (next_addr == n_cnt)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((hs && out_last) ||
                        (fifo_count == 3'd0 && inflight == 2'd0 && !rd_part)) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // p1/p2: valid tags follow particle reads through the memory latency
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= rd_part;
            vld_p2 <= vld_p1;
        end
    end

    // p1/p2: pid and last flag travel beside the valid tags
    always_ff @(posedge clk) begin
        pid_p1  <= mem_addr;
        last_p1 <= (mem_addr == n_cnt);
        pid_p2  <= pid_p1;
        last_p2 <= last_p1;
    end

    // Output buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            assert (!(vld_p2 && fifo_count == 3'd4 && !hs));
            if (vld_p2)
                wr_ptr <= wr_ptr + 2'd1;
            if (hs)
                rd_ptr <= rd_ptr + 2'd1;
            fifo_count <= fifo_count + 3'(vld_p2) - 3'(hs);
        end
    end

    // Output buffer storage: returning words land with their pid and last flag
    always_ff @(posedge clk) begin
        if (vld_p2) begin
            fifo_data[wr_ptr] <= mem_q;
            fifo_pid[wr_ptr]  <= pid_p2;
            fifo_last[wr_ptr] <= last_p2;
        end
    end

endmodule

// File: tb/tb_cell_particle_streamer.sv
// Directed testbench for cell_particle_streamer with a 2-cycle-latency memory model.
module tb_cell_particle_streamer;

    localparam int DW = 96;
    localparam int PN = 220;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst, start, out_ready;
    logic          busy, done, count_err, mem_rden, out_valid, out_last;
    logic [AW-1:0] mem_addr, out_pid;
    logic [DW-1:0] mem_q, q1, out_data;

    logic [DW-1:0] mem [0:255];

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    int            q_pid  [$];
    logic [DW-1:0] q_data [$];
    bit            q_last [$];

    cell_particle_streamer #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .count_err(count_err), .mem_addr(mem_addr), .mem_rden(mem_rden),
        .mem_q(mem_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_pid(out_pid), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Two-cycle read latency memory
    always @(posedge clk) begin
        q1    <= mem[mem_addr];
        mem_q <= q1;
    end

    function automatic logic [DW-1:0] pos(input int i, input int salt);
        return {32'hC000_0000 + 32'(i), 32'hB000_0000 + 32'(salt), 32'hA000_0000 + 32'(i * 7)};
    endfunction

    task automatic load(input logic [DW-1:0] cw, input int salt);
        mem[0] = cw;
        for (int i = 1; i < 256; i++) mem[i] = pos(i, salt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Next cycle becomes cycle 0 with start high
    task automatic begin_start();
        tick();
        cyc   = 0;
        start = 1'b1;
    endtask

    task automatic collect(input int bound, output bit got_done);
        got_done = 1'b0;
        q_pid.delete();
        q_data.delete();
        q_last.delete();
        for (int k = 0; k < bound && !got_done; k++) begin
            tick();
            start     = 1'b0;
            out_ready = 1'b1;
            if (out_valid) begin
                q_pid.push_back(int'(out_pid));
                q_data.push_back(out_data);
                q_last.push_back(out_last);
            end
            if (done) got_done = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
        checks++; if (count_err !== 1'b0) $display("FAIL reset_count_err got=%b exp=0", count_err); else passed++;
        checks++; if (mem_rden !== 1'b0) $display("FAIL reset_mem_rden got=%b exp=0", mem_rden); else passed++;
        checks++; if (mem_addr !== 8'd0) $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
        checks++; if ({out_pid, out_last, out_data} !== '0)
            $display("FAIL reset_out_fields got pid=%0d last=%b data=%h exp=0", out_pid, out_last, out_data); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_count3();
        bit exp_v;
        load(96'd3, 1);
        out_ready = 1'b1;
        begin_start();
        for (int c = 1; c <= 12; c++) begin
            tick();
            start = 1'b0;
            exp_v = (cyc >= 7 && cyc <= 9);
            checks++; if (out_valid !== exp_v)
                $display("FAIL count3_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v); else passed++;
            if (exp_v) begin
                checks++; if ({out_pid, out_last, out_data} !== {8'(cyc - 6), (cyc == 9), mem[cyc - 6]})
                    $display("FAIL count3_word cyc=%0d got pid=%0d last=%b data=%h exp pid=%0d last=%b data=%h",
                             cyc, out_pid, out_last, out_data, cyc - 6, (cyc == 9), mem[cyc - 6]); else passed++;
            end
            checks++; if (done !== (cyc == 10))
                $display("FAIL count3_done cyc=%0d got=%b exp=%b", cyc, done, (cyc == 10)); else passed++;
            checks++; if (busy !== (cyc <= 10))
                $display("FAIL count3_busy cyc=%0d got=%b exp=%b", cyc, busy, (cyc <= 10)); else passed++;
            if (cyc == 1 || cyc == 4) begin
                checks++; if ({mem_rden, mem_addr} !== {1'b1, 8'(cyc == 4)})
                    $display("FAIL count3_read cyc=%0d got rden=%b addr=%0d exp rden=1 addr=%0d",
                             cyc, mem_rden, mem_addr, (cyc == 4)); else passed++;
            end
        end
    endtask

    task automatic test_zero();
        // Bits above the count field are set and must be ignored
        load({64'h0, 32'h0000_0300}, 2);
        out_ready = 1'b1;
        begin_start();
        for (int c = 1; c <= 8; c++) begin
            tick();
            start = 1'b0;
            checks++; if (out_valid !== 1'b0)
                $display("FAIL zero_valid cyc=%0d got=%b exp=0", cyc, out_valid); else passed++;
            checks++; if (done !== (cyc == 5))
                $display("FAIL zero_done cyc=%0d got=%b exp=%b", cyc, done, (cyc == 5)); else passed++;
        end
        checks++; if ({count_err, busy} !== 2'b00)
            $display("FAIL zero_idle got count_err=%b busy=%b exp=0,0", count_err, busy); else passed++;
    endtask

    task automatic test_backpressure();
        int n_reads;
        int max_addr;
        bit got;
        n_reads = 0; max_addr = 0;
        load(96'd5, 3);
        out_ready = 1'b1;
        begin_start();
        for (int c = 1; c <= 20; c++) begin
            tick();
            start     = 1'b0;
            out_ready = (cyc < 7);
            if (cyc >= 2 && mem_rden) begin
                n_reads++;
                if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            end
            if (cyc >= 7) begin
                checks++; if ({out_valid, out_pid, out_data} !== {1'b1, 8'd1, mem[1]})
                    $display("FAIL bp_hold cyc=%0d got valid=%b pid=%0d data=%h exp valid=1 pid=1 data=%h",
                             cyc, out_valid, out_pid, out_data, mem[1]); else passed++;
            end
        end
        checks++; if (n_reads !== 4) $display("FAIL bp_reads got=%0d exp=4", n_reads); else passed++;
        checks++; if (max_addr !== 4) $display("FAIL bp_max_addr got=%0d exp=4", max_addr); else passed++;
        collect(60, got);
        checks++; if (got !== 1'b1) $display("FAIL bp_done_timeout got=%b exp=1", got); else passed++;
        checks++; if (q_pid.size() !== 5) $display("FAIL bp_words got=%0d exp=5", q_pid.size()); else passed++;
        for (int i = 0; i < q_pid.size() && i < 5; i++) begin
            checks++; if (q_pid[i] !== i + 1 || q_data[i] !== mem[i + 1] || q_last[i] !== (i == 4))
                $display("FAIL bp_word%0d got pid=%0d last=%b data=%h exp pid=%0d last=%b data=%h",
                         i, q_pid[i], q_last[i], q_data[i], i + 1, (i == 4), mem[i + 1]); else passed++;
        end
    endtask

    task automatic test_count_overflow();
        bit got;
        load(96'h1FF, 4);
        out_ready = 1'b1;
        begin_start();
        collect(400, got);
        checks++; if (got !== 1'b1) $display("FAIL ovf_done_timeout got=%b exp=1", got); else passed++;
        checks++; if (count_err !== 1'b1) $display("FAIL ovf_count_err got=%b exp=1", count_err); else passed++;
        checks++; if (q_pid.size() !== 219) $display("FAIL ovf_words got=%0d exp=219", q_pid.size()); else passed++;
        for (int i = 0; i < q_pid.size() && i < 219; i++) begin
            checks++; if (q_pid[i] !== i + 1 || q_data[i] !== mem[i + 1] || q_last[i] !== (i == 218))
                $display("FAIL ovf_word%0d got pid=%0d last=%b exp pid=%0d last=%b",
                         i, q_pid[i], q_last[i], i + 1, (i == 218)); else passed++;
        end
        tick();
        checks++; if ({count_err, busy} !== 2'b10)
            $display("FAIL ovf_sticky got count_err=%b busy=%b exp=1,0", count_err, busy); else passed++;
        load(96'd2, 5);
        begin_start();
        tick();
        start = 1'b0;
        checks++; if ({count_err, busy} !== 2'b01)
            $display("FAIL ovf_clear got count_err=%b busy=%b exp=0,1", count_err, busy); else passed++;
        collect(40, got);
        checks++; if (got !== 1'b1 || q_pid.size() !== 2)
            $display("FAIL ovf_next_stream got done=%b words=%0d exp done=1 words=2", got, q_pid.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        bit got;
        load(96'd10, 6);
        out_ready = 1'b1;
        begin_start();
        for (int c = 1; c <= 8; c++) begin
            tick();
            start = 1'b0;
        end
        rst = 1'b1;
        tick();
        checks++; if ({busy, done, count_err, mem_rden, mem_addr, out_valid, out_pid, out_last, out_data} !== '0)
            $display("FAIL midrst_outputs got busy=%b done=%b err=%b rden=%b addr=%0d valid=%b pid=%0d last=%b data=%h exp all 0",
                     busy, done, count_err, mem_rden, mem_addr, out_valid, out_pid, out_last, out_data); else passed++;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if ({out_valid, done, busy} !== 3'b000)
                $display("FAIL midrst_quiet cyc=%0d got valid=%b done=%b busy=%b exp 0,0,0", cyc, out_valid, done, busy); else passed++;
        end
        load(96'd3, 7);
        begin_start();
        collect(40, got);
        checks++; if (got !== 1'b1 || q_pid.size() !== 3)
            $display("FAIL midrst_restart got done=%b words=%0d exp done=1 words=3", got, q_pid.size()); else passed++;
        for (int i = 0; i < q_pid.size() && i < 3; i++) begin
            checks++; if (q_pid[i] !== i + 1 || q_data[i] !== pos(i + 1, 7))
                $display("FAIL midrst_word%0d got pid=%0d data=%h exp pid=%0d data=%h",
                         i, q_pid[i], q_data[i], i + 1, pos(i + 1, 7)); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        bit exp_v, exp_done, exp_busy, cnt_rd;
        int exp_pid;
        load(96'd4, 8);
        out_ready = 1'b1;
        begin_start();
        for (int c = 1; c <= 25; c++) begin
            tick();
            start    = (cyc == 2 || cyc == 5 || cyc == 8 || cyc == 11 || cyc == 12);
            exp_v    = (cyc >= 7 && cyc <= 10) || (cyc >= 19 && cyc <= 22);
            exp_pid  = (cyc <= 12) ? cyc - 6 : cyc - 18;
            exp_done = (cyc == 11 || cyc == 23);
            exp_busy = (cyc <= 11) || (cyc >= 13 && cyc <= 23);
            cnt_rd   = mem_rden && (mem_addr == 8'd0);
            checks++; if (out_valid !== exp_v)
                $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v); else passed++;
            if (exp_v) begin
                checks++; if ({out_pid, out_last, out_data} !== {8'(exp_pid), (exp_pid == 4), mem[exp_pid]})
                    $display("FAIL b2b_word cyc=%0d got pid=%0d last=%b exp pid=%0d last=%b",
                             cyc, out_pid, out_last, exp_pid, (exp_pid == 4)); else passed++;
            end
            checks++; if (done !== exp_done)
                $display("FAIL b2b_done cyc=%0d got=%b exp=%b", cyc, done, exp_done); else passed++;
            checks++; if (busy !== exp_busy)
                $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); else passed++;
            checks++; if (cnt_rd !== (cyc == 1 || cyc == 13))
                $display("FAIL b2b_count_read cyc=%0d got=%b exp=%b", cyc, cnt_rd, (cyc == 1 || cyc == 13)); else passed++;
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        load(96'd0, 0);
        test_reset();
        test_count3();
        test_zero();
        test_backpressure();
        test_count_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
